// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned REQ_HOST = 0;
  localparam int unsigned REQ_CTRL = 1;
  localparam int unsigned REQ_RDBK = 2;

  typedef enum logic {
    StIdle,
    StOwn
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_write_readbar;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_data_in;
  logic [DATA_W-1:0]       mem_data_out;
  logic                    busy;

  modport master (
    output req, lock, we, addr, wdata, mem_data_out,
    input  gnt, rvalid, rdata, mem_write_readbar, mem_addr, mem_data_in, busy
  );

  modport slave (
    input  req, lock, we, addr, wdata, mem_data_out,
    output gnt, rvalid, rdata, mem_write_readbar, mem_addr, mem_data_in, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first candidate at or above ptr, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [N_REQ-1:0] cand;
  int unsigned      idx;

  always_comb begin
    // Excluded requester still wins when it is the only one asking.
    cand = req & ~excl;
    if (cand == '0) begin
      cand = req;
    end
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (!valid && cand[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single-port main memory with burst lock and a
// per-owner burst cap; captures read data for the current owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned MAX_BURST = 16
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d, burst_inc;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0]  owner, owner_next, pick_ptr;
  logic [N_REQ-1:0]  pick_excl, pick_win;
  logic              pick_valid;
  logic              xfer, xfer_rd, release_own;

  always_comb begin
    owner = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt_q[i]) begin
        owner = IDX_W'(i);
      end
    end
  end

  assign owner_next  = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign xfer        = |(gnt_q & bus.req);
  assign xfer_rd     = xfer && !bus.we[owner];
  assign burst_inc   = burst_cnt_q + 8'd1;
  // A missing request ends ownership as surely as an unlocked or capped transfer.
  assign release_own = (state_q == StOwn) &&
                       (!xfer || !bus.lock[owner] || (burst_inc == 8'(MAX_BURST)));

  // On release the search starts just past the old owner, which is excluded.
  assign pick_ptr  = (state_q == StOwn) ? owner_next : rr_ptr_q;
  assign pick_excl = (state_q == StOwn) ? gnt_q : '0;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req    (bus.req),
    .ptr    (pick_ptr),
    .excl   (pick_excl),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d     = StOwn;
          gnt_d       = pick_win;
          burst_cnt_d = '0;
        end
      end
      StOwn: begin
        if (release_own) begin
          rr_ptr_d    = owner_next;
          burst_cnt_d = '0;
          if (pick_valid) begin
            gnt_d = pick_win;
          end else begin
            gnt_d   = '0;
            state_d = StIdle;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_inc;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  assign rvalid_d = xfer_rd ? gnt_q : '0;
  assign rdata_d  = xfer_rd ? bus.mem_data_out : rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Memory sees nothing but zeros unless the owner is actively requesting.
  assign bus.mem_write_readbar = xfer & bus.we[owner];
  assign bus.mem_addr          = xfer ? bus.addr[owner*ADDR_W +: ADDR_W] : '0;
  assign bus.mem_data_in       = xfer ? bus.wdata[owner*DATA_W +: DATA_W] : '0;

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = |gnt_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory (1024 x 32, 10-bit word address) between up to N_REQ requesters: host input loader, matrix control unit and result readback port.
- Round-robin arbitration with per-requester burst lock and a starvation cap.
- Sits between the requesters and mainMemory; owns mainMemory's write_readBar, address and data_in.
- Captures read data for the current owner.

Parameters:
- N_REQ, 3, number of requesters; index 0 = host loader, 1 = control unit, 2 = readback.
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, memory data width.
- MAX_BURST, 16, maximum consecutive transfers one owner may hold while lock is high; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester access request; hold high until the transfer is granted.
- lock  in  N_REQ  per-requester burst hold; keeps ownership across consecutive transfers.
- we  in  N_REQ  per-requester write(1)/read(0).
- addr  in  N_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  per-requester write data, sliced the same way.
- gnt  out  N_REQ  registered one-hot ownership; never more than one bit high.
- rvalid  out  N_REQ  one-cycle pulse; rdata holds read data for requester i.
- rdata  out  DATA_W  registered read data.
- mem_write_readbar  out  1  to memory.
- mem_addr  out  ADDR_W  to memory.
- mem_data_in  out  DATA_W  to memory.
- mem_data_out  in  DATA_W  from memory; combinational read of mem_addr.
- busy  out  1  high while any gnt bit is high.

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, gnt = 0, rvalid = 0, rdata = 0, rr_ptr = 0, burst_cnt = 0.
  - mem_write_readbar = 0, mem_addr = 0 and mem_data_in = 0 follow combinationally from gnt = 0.
  - Reset asserted mid-burst aborts the burst. A write accepted in the edge coinciding with reset assertion is not guaranteed.
- States:
  - IDLE (no owner).
  - OWN (owner = index of the high gnt bit).
- Transfer: occurs in any cycle where gnt[i] & req[i].
  - mem_write_readbar = we[i]; mem_addr and mem_data_in = slice i, combinationally.
  - When gnt = 0 or req[owner] = 0, all memory outputs are 0. There are never spurious writes.
- Read latency: a read transfer in cycle t gives rdata = mem_data_out and rvalid[i] = 1 in cycle t+1. Write transfers produce no rvalid.
- Arbitration: the winner is the first requesting index searched from rr_ptr upward, wrapping modulo N_REQ. It is evaluated each edge where a grant decision is due.
- IDLE: if any req, the winner gets gnt at the next edge and burst_cnt = 0; otherwise stay IDLE.
  - Grant latency from req rise to gnt is 1 cycle. The first transfer occurs in the cycle gnt is high.
- OWN, per edge:
  - On a transfer, burst_cnt++.
  - Release when any of:
    - the transfer had lock[owner] = 0;
    - req[owner] = 0 (no transfer);
    - burst_cnt reaches MAX_BURST.
  - On release: rr_ptr = owner+1 mod N_REQ. The arbiter re-arbitrates in the same edge with rr_ptr' and excludes the old owner unless it is the only requester.
    - If there is a winner, gnt switches directly (no bubble); otherwise go to IDLE.
  - Otherwise hold ownership.
- Single transfer (lock = 0): exactly one transfer per grant. The requester deasserts req, or the arbiter drops gnt after the edge.
- Simultaneous requests: resolved by rr_ptr only. No requester waits more than (N_REQ-1)*MAX_BURST + N_REQ cycles once req is high.
- gnt changes only on clock edges; rvalid is never high for a non-owner's transfer.

Decomposition:
- Shared package: state encoding (IDLE, OWN), requester index constants (REQ_HOST=0, REQ_CTRL=1, REQ_RDBK=2), memory width constants (ADDR_W=10, DATA_W=32).
- One sub-module: rr_picker (combinational round-robin priority encoder).
  - Inputs: request vector, rr_ptr, exclude mask.
  - Outputs: one-hot winner, valid.

Test Plan:
- Reset then req = 3'b010, we = 0, addr1 = 10'h005, memory[5] = 32'h3F800000 -> gnt = 3'b010 one cycle later; rvalid[1] = 1 with rdata = 32'h3F800000 one cycle after the transfer; then gnt = 0.
- req = 3'b111 held, lock = 0, all reads -> grants cycle 0,1,2,0,... every cycle with no bubble; each rvalid pulses once per grant.
- Host burst: req0 = lock0 = 1, writes to addr 0..19 with req1 also high, MAX_BURST = 16 -> 16 writes to addresses 0..15, then gnt moves to 1; host regains ownership after one transfer by requester 1 when lock1 = 0.
- req0 dropped mid-burst after 3 transfers -> release at that edge; mem_write_readbar = 0 while no transfer; ownership goes to a waiting requester or IDLE.
- Write then read same address: requester 2 writes 32'hDEADBEEF to 10'h3FF, then reads it -> rdata = 32'hDEADBEEF, rvalid[2] one cycle after the read.
- Assert reset low mid-burst (owner 1, burst_cnt = 5) -> gnt, rvalid and mem_write_readbar go to 0 immediately (asynchronously); after release, first grant follows rr_ptr = 0.
